// File: rtl/hash_capture_display.sv
// rtl/hash_capture_display.sv - capture buffer for emulator output words with button-stepped hex display
module hash_capture_display #(
   parameter int DATA_W          = 8,
   parameter int DEPTH           = 64,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int SEG_ACTIVE_LOW  = 0
) (
   input  logic                           clk,
   input  logic                           nreset,
   input  logic [DATA_W-1:0]              data_i,
   input  logic                           valid_i,
   input  logic                           last_i,
   input  logic                           clear_i,
   input  logic                           btn_next_i,
   input  logic                           btn_prev_i,
   output logic [7*(DATA_W/4)-1:0]        seg_o,
   output logic [$clog2(DEPTH)-1:0]       idx_o,
   output logic [$clog2(DEPTH):0]         count_o,
   output logic                           done_o,
   output logic                           full_o,
   output logic                           overflow_o
);

   localparam int NDIG = DATA_W / 4;
   localparam int AW   = $clog2(DEPTH);
   localparam int CW   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [7*NDIG-1:0] SEG_BLANK = (SEG_ACTIVE_LOW != 0) ? '1 : '0;

   typedef enum logic [1:0] {S_EMPTY, S_CAPTURE, S_DONE, S_FULL} state_t;

   state_t            r_state, w_state_nxt;
   logic [AW:0]       r_count, w_cnt_inc, w_idx_inc;
   logic [AW-1:0]     r_idx, w_cnt_m1;
   logic              r_overflow, w_wr, w_ovf_set, w_done;
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] w_rd_word;
   logic [7*NDIG-1:0] r_seg, w_seg_lit;
   logic [1:0]        w_btn_raw, w_step;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
         4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
         4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
         4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
      endcase
   endfunction

   assign w_cnt_inc = r_count + (AW+1)'(1);
   assign w_idx_inc = {1'b0, r_idx} + (AW+1)'(1);
   // Low AW bits of count wrap to 0 when full, so minus one still lands on DEPTH-1.
   assign w_cnt_m1  = r_count[AW-1:0] - AW'(1);

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) r_state <= S_EMPTY;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (clear_i) begin
         w_state_nxt = S_EMPTY;
      end else if (valid_i && (r_state == S_EMPTY || r_state == S_CAPTURE)) begin
         if (last_i)                             w_state_nxt = S_DONE;
         else if (w_cnt_inc == (AW+1)'(DEPTH))   w_state_nxt = S_FULL;
         else                                    w_state_nxt = S_CAPTURE;
      end
   end

   always_comb begin
      w_wr      = 1'b0;
      w_ovf_set = 1'b0;
      w_done    = (r_state == S_DONE);
      if (valid_i && !clear_i) begin
         case (r_state)
            S_EMPTY, S_CAPTURE: w_wr      = 1'b1;
            default:            w_ovf_set = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else if (clear_i) begin
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_wr)      r_count    <= w_cnt_inc;
         if (w_ovf_set) r_overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_count[AW-1:0]] <= data_i;
   end

   assign w_btn_raw = {btn_prev_i, btn_next_i};

   for (genvar g = 0; g < 2; g++) begin : g_btn
      logic          r_sync1, r_sync2, r_deb, r_deb_d;
      logic [CW-1:0] r_cnt;
      always_ff @(posedge clk or negedge nreset) begin
         if (!nreset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_deb   <= 1'b0;
            r_deb_d <= 1'b0;
            r_cnt   <= '0;
         end else begin
            r_sync1 <= w_btn_raw[g];
            r_sync2 <= r_sync1;
            r_deb_d <= r_deb;
            if (r_sync2 == r_deb) begin
               r_cnt <= '0;
            end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
               r_deb <= r_sync2;
               r_cnt <= '0;
            end else begin
               r_cnt <= r_cnt + CW'(1);
            end
         end
      end
      assign w_step[g] = r_deb & ~r_deb_d;
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_idx <= '0;
      end else if (clear_i || r_count == '0) begin
         r_idx <= '0;
      end else if (w_step[0] && !w_step[1]) begin
         r_idx <= (w_idx_inc == r_count) ? '0 : w_idx_inc[AW-1:0];
      end else if (w_step[1] && !w_step[0]) begin
         r_idx <= (r_idx == '0) ? w_cnt_m1 : r_idx - AW'(1);
      end
   end

   assign w_rd_word = r_mem[r_idx];

   for (genvar k = 0; k < NDIG; k++) begin : g_dig
      assign w_seg_lit[7*k +: 7] = hex7(w_rd_word[4*k +: 4]);
   end

   // Entries at or beyond count were never written in this capture, so they stay blank.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) r_seg <= SEG_BLANK;
      else         r_seg <= ((({1'b0, r_idx}) < r_count) ? w_seg_lit : '0) ^ SEG_BLANK;
   end

   assign seg_o      = r_seg;
   assign idx_o      = r_idx;
   assign count_o    = r_count;
   assign done_o     = w_done;
   assign full_o     = (r_count == (AW+1)'(DEPTH));
   assign overflow_o = r_overflow;

endmodule

// File: tb/tb_hash_capture_display.sv
// tb/tb_hash_capture_display.sv - directed bench for hash_capture_display (DEPTH=4, DEBOUNCE_CYCLES=4)
module tb_hash_capture_display;

   logic        clk = 1'b0;
   logic        nreset = 1'b0;
   logic [7:0]  data_i = '0;
   logic        valid_i = 1'b0, last_i = 1'b0, clear_i = 1'b0;
   logic        btn_next_i = 1'b0, btn_prev_i = 1'b0;
   logic [13:0] seg_o, seg_n_o;
   logic [1:0]  idx_o, idx_n_o;
   logic [2:0]  count_o, count_n_o;
   logic        done_o, full_o, overflow_o, done_n_o, full_n_o, overflow_n_o;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   hash_capture_display #(.DATA_W(8), .DEPTH(4), .DEBOUNCE_CYCLES(4), .SEG_ACTIVE_LOW(0)) dut (
      .clk(clk), .nreset(nreset), .data_i(data_i), .valid_i(valid_i), .last_i(last_i),
      .clear_i(clear_i), .btn_next_i(btn_next_i), .btn_prev_i(btn_prev_i),
      .seg_o(seg_o), .idx_o(idx_o), .count_o(count_o), .done_o(done_o),
      .full_o(full_o), .overflow_o(overflow_o));

   hash_capture_display #(.DATA_W(8), .DEPTH(4), .DEBOUNCE_CYCLES(4), .SEG_ACTIVE_LOW(1)) dut_n (
      .clk(clk), .nreset(nreset), .data_i(data_i), .valid_i(valid_i), .last_i(last_i),
      .clear_i(clear_i), .btn_next_i(btn_next_i), .btn_prev_i(btn_prev_i),
      .seg_o(seg_n_o), .idx_o(idx_n_o), .count_o(count_n_o), .done_o(done_n_o),
      .full_o(full_n_o), .overflow_o(overflow_n_o));

   task automatic push(input logic [7:0] d, input logic l);
      valid_i = 1'b1; data_i = d; last_i = l;
      @(negedge clk);
      valid_i = 1'b0; last_i = 1'b0;
   endtask

   task automatic pulse_clear();
      clear_i = 1'b1;
      @(negedge clk);
      clear_i = 1'b0;
   endtask

   // Holds the buttons well past the debounce latency, then releases; counts idx_o changes.
   task automatic press(input logic nx, input logic pv, output int changes);
      logic [1:0] last_idx;
      changes = 0;
      last_idx = idx_o;
      btn_next_i = nx; btn_prev_i = pv;
      repeat (14) begin
         @(negedge clk);
         if (idx_o !== last_idx) begin changes++; last_idx = idx_o; end
      end
      btn_next_i = 1'b0; btn_prev_i = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (idx_o !== last_idx) begin changes++; last_idx = idx_o; end
      end
   endtask

   task automatic test_reset();
      nreset = 1'b0;
      repeat (2) @(negedge clk);
      n_vec++; if (count_o !== 3'd0) begin n_err++; $display("FAIL rst_count: got %0d expected 0", count_o); end
      n_vec++; if (idx_o !== 2'd0) begin n_err++; $display("FAIL rst_idx: got %0d expected 0", idx_o); end
      n_vec++; if ({done_o, full_o, overflow_o} !== 3'b000) begin n_err++; $display("FAIL rst_flags: got %b expected 000", {done_o, full_o, overflow_o}); end
      n_vec++; if (seg_o !== 14'h0000) begin n_err++; $display("FAIL rst_seg: got %h expected 0000", seg_o); end
      n_vec++; if (seg_n_o !== 14'h3FFF) begin n_err++; $display("FAIL rst_seg_n: got %h expected 3fff", seg_n_o); end
      nreset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_capture();
      push(8'h12, 1'b0);
      push(8'hA5, 1'b0);
      push(8'h3C, 1'b1);
      n_vec++; if (count_o !== 3'd3) begin n_err++; $display("FAIL cap_count: got %0d expected 3", count_o); end
      n_vec++; if (done_o !== 1'b1) begin n_err++; $display("FAIL cap_done: got %b expected 1", done_o); end
      n_vec++; if (full_o !== 1'b0) begin n_err++; $display("FAIL cap_full: got %b expected 0", full_o); end
      n_vec++; if (seg_o !== {7'h06, 7'h5B}) begin n_err++; $display("FAIL cap_seg: got %h expected %h", seg_o, {7'h06, 7'h5B}); end
      n_vec++; if (seg_n_o !== ~{7'h06, 7'h5B}) begin n_err++; $display("FAIL cap_seg_n: got %h expected %h", seg_n_o, ~{7'h06, 7'h5B}); end
      push(8'hFF, 1'b0);
      n_vec++; if (overflow_o !== 1'b1) begin n_err++; $display("FAIL done_ovf: got %b expected 1", overflow_o); end
      n_vec++; if (count_o !== 3'd3) begin n_err++; $display("FAIL done_count: got %0d expected 3", count_o); end
   endtask

   task automatic test_browse();
      int ch;
      repeat (2) begin
         btn_next_i = 1'b1;
         @(negedge clk);
         btn_next_i = 1'b0;
         repeat (3) @(negedge clk);
      end
      repeat (6) @(negedge clk);
      n_vec++; if (idx_o !== 2'd0) begin n_err++; $display("FAIL glitch_idx: got %0d expected 0", idx_o); end
      press(1'b1, 1'b0, ch);
      n_vec++; if (ch !== 1) begin n_err++; $display("FAIL next1_steps: got %0d expected 1", ch); end
      n_vec++; if (idx_o !== 2'd1) begin n_err++; $display("FAIL next1_idx: got %0d expected 1", idx_o); end
      n_vec++; if (seg_o !== {7'h77, 7'h6D}) begin n_err++; $display("FAIL next1_seg: got %h expected %h", seg_o, {7'h77, 7'h6D}); end
      press(1'b1, 1'b0, ch);
      n_vec++; if (idx_o !== 2'd2) begin n_err++; $display("FAIL next2_idx: got %0d expected 2", idx_o); end
      n_vec++; if (seg_o !== {7'h4F, 7'h39}) begin n_err++; $display("FAIL next2_seg: got %h expected %h", seg_o, {7'h4F, 7'h39}); end
      press(1'b1, 1'b0, ch);
      n_vec++; if (idx_o !== 2'd0) begin n_err++; $display("FAIL next_wrap_idx: got %0d expected 0", idx_o); end
      n_vec++; if (seg_o !== {7'h06, 7'h5B}) begin n_err++; $display("FAIL next_wrap_seg: got %h expected %h", seg_o, {7'h06, 7'h5B}); end
      press(1'b0, 1'b1, ch);
      n_vec++; if (ch !== 1) begin n_err++; $display("FAIL prev_steps: got %0d expected 1", ch); end
      n_vec++; if (idx_o !== 2'd2) begin n_err++; $display("FAIL prev_wrap_idx: got %0d expected 2", idx_o); end
   endtask

   task automatic test_both_buttons();
      int ch;
      press(1'b1, 1'b1, ch);
      n_vec++; if (ch !== 0) begin n_err++; $display("FAIL both_steps: got %0d expected 0", ch); end
      n_vec++; if (idx_o !== 2'd2) begin n_err++; $display("FAIL both_idx: got %0d expected 2", idx_o); end
   endtask

   task automatic test_clear_with_valid();
      clear_i = 1'b1; valid_i = 1'b1; data_i = 8'h55;
      @(negedge clk);
      clear_i = 1'b0; valid_i = 1'b0;
      n_vec++; if (count_o !== 3'd0) begin n_err++; $display("FAIL clr_count: got %0d expected 0", count_o); end
      n_vec++; if ({done_o, overflow_o} !== 2'b00) begin n_err++; $display("FAIL clr_flags: got %b expected 00", {done_o, overflow_o}); end
      n_vec++; if (idx_o !== 2'd0) begin n_err++; $display("FAIL clr_idx: got %0d expected 0", idx_o); end
      @(negedge clk);
      n_vec++; if (seg_o !== 14'h0000) begin n_err++; $display("FAIL clr_seg: got %h expected 0000", seg_o); end
      push(8'h7E, 1'b0);
      n_vec++; if (count_o !== 3'd1) begin n_err++; $display("FAIL post_clr_count: got %0d expected 1", count_o); end
      n_vec++; if (seg_o !== 14'h0000) begin n_err++; $display("FAIL write_edge_seg: got %h expected 0000", seg_o); end
      @(negedge clk);
      n_vec++; if (seg_o !== {7'h07, 7'h79}) begin n_err++; $display("FAIL post_clr_seg: got %h expected %h", seg_o, {7'h07, 7'h79}); end
   endtask

   task automatic test_empty_press();
      int ch;
      pulse_clear();
      press(1'b1, 1'b0, ch);
      n_vec++; if (idx_o !== 2'd0) begin n_err++; $display("FAIL empty_next_idx: got %0d expected 0", idx_o); end
      n_vec++; if (seg_o !== 14'h0000) begin n_err++; $display("FAIL empty_seg: got %h expected 0000", seg_o); end
      press(1'b0, 1'b1, ch);
      n_vec++; if (idx_o !== 2'd0) begin n_err++; $display("FAIL empty_prev_idx: got %0d expected 0", idx_o); end
   endtask

   task automatic test_full_overflow();
      int ch;
      pulse_clear();
      push(8'h01, 1'b0);
      push(8'h02, 1'b0);
      push(8'h03, 1'b0);
      n_vec++; if (full_o !== 1'b0) begin n_err++; $display("FAIL full_early: got %b expected 0", full_o); end
      push(8'h04, 1'b0);
      n_vec++; if ({full_o, done_o, overflow_o} !== 3'b100) begin n_err++; $display("FAIL full4_flags: got %b expected 100", {full_o, done_o, overflow_o}); end
      n_vec++; if (count_o !== 3'd4) begin n_err++; $display("FAIL full4_count: got %0d expected 4", count_o); end
      push(8'h99, 1'b0);
      n_vec++; if ({full_o, overflow_o} !== 2'b11) begin n_err++; $display("FAIL ovf5_flags: got %b expected 11", {full_o, overflow_o}); end
      n_vec++; if (count_o !== 3'd4) begin n_err++; $display("FAIL ovf5_count: got %0d expected 4", count_o); end
      n_vec++; if (seg_o !== {7'h3F, 7'h06}) begin n_err++; $display("FAIL full_seg0: got %h expected %h", seg_o, {7'h3F, 7'h06}); end
      press(1'b0, 1'b1, ch);
      n_vec++; if (idx_o !== 2'd3) begin n_err++; $display("FAIL full_prev_idx: got %0d expected 3", idx_o); end
      n_vec++; if (seg_o !== {7'h3F, 7'h66}) begin n_err++; $display("FAIL full_prev_seg: got %h expected %h", seg_o, {7'h3F, 7'h66}); end
   endtask

   task automatic test_async_reset();
      int ch;
      pulse_clear();
      push(8'h11, 1'b0);
      push(8'h22, 1'b0);
      press(1'b1, 1'b0, ch);
      n_vec++; if (idx_o !== 2'd1) begin n_err++; $display("FAIL pre_rst_idx: got %0d expected 1", idx_o); end
      valid_i = 1'b1; data_i = 8'h33;
      #2 nreset = 1'b0;
      #1;
      n_vec++; if (count_o !== 3'd0) begin n_err++; $display("FAIL arst_count: got %0d expected 0", count_o); end
      n_vec++; if (idx_o !== 2'd0) begin n_err++; $display("FAIL arst_idx: got %0d expected 0", idx_o); end
      n_vec++; if ({done_o, full_o, overflow_o} !== 3'b000) begin n_err++; $display("FAIL arst_flags: got %b expected 000", {done_o, full_o, overflow_o}); end
      n_vec++; if (seg_o !== 14'h0000) begin n_err++; $display("FAIL arst_seg: got %h expected 0000", seg_o); end
      n_vec++; if (seg_n_o !== 14'h3FFF) begin n_err++; $display("FAIL arst_seg_n: got %h expected 3fff", seg_n_o); end
      valid_i = 1'b0;
      @(negedge clk);
      nreset = 1'b1;
      @(negedge clk);
      push(8'h3C, 1'b1);
      n_vec++; if (count_o !== 3'd1) begin n_err++; $display("FAIL restart_count: got %0d expected 1", count_o); end
      n_vec++; if (done_o !== 1'b1) begin n_err++; $display("FAIL restart_done: got %b expected 1", done_o); end
      @(negedge clk);
      n_vec++; if (seg_o !== {7'h4F, 7'h39}) begin n_err++; $display("FAIL restart_seg: got %h expected %h", seg_o, {7'h4F, 7'h39}); end
   endtask

   initial begin
      test_reset();
      test_capture();
      test_browse();
      test_both_buttons();
      test_clear_with_valid();
      test_empty_press();
      test_full_overflow();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
